// File: rtl/fft_b4_frame_ctrl.sv
// Frame sequencer for the radix-4 single-path pipeline FFT: shared enable, twiddle addresses and
// output valid/SOP/EOP tags. Defining FFT_FRAME_CTRL_ERR_EN adds a sticky protocol-error flag.
module fft_b4_frame_ctrl #(
  parameter int unsigned STAGES  = 3,
  parameter int unsigned LOG2N   = 6,
  parameter int unsigned LATENCY = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      enable,
  output logic [LOG2N-1:0]          sample_idx,
  output logic [STAGES*LOG2N-1:0]   tw_addr,
  output logic                      out_valid,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic                      busy,
  output logic                      err
);

  localparam int unsigned N        = 1 << LOG2N;
  // Flush length rounded up to 4 keeps the stages' mod-4 counters aligned to frame starts.
  localparam int unsigned FlushLen = ((LATENCY + 3) / 4) * 4;
  localparam logic [6:0]  FlushLast = 7'(FlushLen - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e           state_q, state_d;
  logic [LOG2N-1:0] idx_q, idx_d;
  logic             pend_q, pend_d;
  logic [1:0]       phase_q, phase_d;
  logic [6:0]       flush_q, flush_d;
  logic [2:0]       tag_q [LATENCY];
  logic [2:0]       tag_d [LATENCY];
  logic [2:0]       tag_in;
  logic             accept;
  logic             idx_last;

  function automatic logic [LOG2N-1:0] tw_calc(input logic [LOG2N-1:0] n, input int unsigned s);
    int unsigned len, j, p, q, prod;
    len  = N >> (2 * s);
    j    = 32'(n) & (len - 1);
    p    = j & (len / 4 - 1);
    q    = j >> (LOG2N - 2 * s - 2);
    prod = (p * q) << (2 * s);
    return LOG2N'(prod);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      phase_q <= '0;
      flush_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      phase_q <= phase_d;
      flush_q <= flush_d;
      for (int unsigned i = 0; i < LATENCY; i++) tag_q[i] <= tag_d[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    flush_d  = flush_q;
    idx_last = (idx_q == '1);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          idx_d   = '0;
          pend_d  = 1'b0;
        end
      end
      StRun: begin
        if (start) pend_d = 1'b1;
        if (accept) begin
          idx_d = idx_q + LOG2N'(1);
          if (idx_last) begin
            // A start coinciding with the last sample also chains the next frame.
            if (pend_q || start) begin
              pend_d = 1'b0;
            end else begin
              state_d = StFlush;
              flush_d = '0;
            end
          end
        end
      end
      StFlush: begin
        flush_d = flush_q + 7'd1;
        if (start) pend_d = 1'b1;
        if (flush_q == FlushLast) begin
          flush_d = '0;
          if (pend_q || start) begin
            state_d = StRun;
            idx_d   = '0;
            pend_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == StRun);
    enable     = (in_ready & in_valid) | (state_q == StFlush);
    busy       = (state_q != StIdle);
    accept     = in_ready & in_valid;
    sample_idx = idx_q;
    phase_d    = phase_q + {1'b0, enable};
    tw_addr    = '0;
    for (int unsigned s = 0; s < STAGES; s++) tw_addr[s*LOG2N +: LOG2N] = tw_calc(idx_q, s);
    tag_in = {accept, accept & (idx_q == '0), accept & (idx_q == '1)};
    tag_d  = tag_q;
    if (enable) begin
      tag_d[0] = tag_in;
      for (int unsigned i = 1; i < LATENCY; i++) tag_d[i] = tag_q[i-1];
    end
    out_valid = enable & tag_q[LATENCY-1][2];
    out_sop   = out_valid & tag_q[LATENCY-1][1];
    out_eop   = out_valid & tag_q[LATENCY-1][0];
  end

`ifdef FFT_FRAME_CTRL_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q
          | (in_valid & (state_q != StRun))
          | (start & pend_q)
          | (start & (state_q == StRun) & (idx_q == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_b4_frame_ctrl.sv
// Self-checking bench for fft_b4_frame_ctrl: per-cycle comparison against a frame-level model.
module tb_fft_b4_frame_ctrl;
  localparam int STAGES  = 3;
  localparam int LOG2N   = 6;
  localparam int LATENCY = 8;
  localparam int N       = 64;
  localparam int F       = ((LATENCY + 3) / 4) * 4;

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic in_ready, enable, out_valid, out_sop, out_eop, busy, err;
  logic [LOG2N-1:0]        sample_idx;
  logic [STAGES*LOG2N-1:0] tw_addr;

  always #5 clk = ~clk;

  fft_b4_frame_ctrl #(.STAGES(STAGES), .LOG2N(LOG2N), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .enable(enable), .sample_idx(sample_idx), .tw_addr(tw_addr), .out_valid(out_valid),
    .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .err(err)
  );

  typedef struct {int due; bit sop; bit eop;} tag_t;
  tag_t exq[$];

  int checks = 0;
  int errors = 0;
  int m_state;  // 0 idle, 1 run, 2 flush
  int m_idx, m_fl, en_cnt, obs_en_cnt;
  bit m_pend, m_err;
  int outs, sops, eops, flush_cyc, sop_at, eop_at;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  function automatic int tw_ref(input int n, input int s);
    int len, j, p, q;
    len = N / (1 << (2 * s));
    j   = n % len;
    p   = j % (len / 4);
    q   = j / (len / 4);
    return (p * q * (1 << (2 * s))) % N;
  endfunction

  task automatic clear_counts();
    outs = 0; sops = 0; eops = 0; flush_cyc = 0; sop_at = -1; eop_at = -1;
  endtask

  task automatic step(input bit st, input bit iv);
    bit e_ready, e_en, e_ov, e_sop, e_eop, acc;
    logic [31:0] tw_s;
    @(negedge clk);
    start = st; in_valid = iv;
    #1;
    e_ready = (m_state == 1);
    e_en    = (m_state == 1) ? iv : (m_state == 2);
    acc     = e_ready && iv;
    e_ov = 0; e_sop = 0; e_eop = 0;
    if (acc && m_idx == 0) check("phase_at_sample0", obs_en_cnt % 4, 0);
    if (e_en) begin
      en_cnt++;
      if (exq.size() > 0 && exq[0].due == en_cnt) begin
        e_ov = 1; e_sop = exq[0].sop; e_eop = exq[0].eop;
        void'(exq.pop_front());
      end
    end
    if (acc) exq.push_back(tag_t'{en_cnt + LATENCY, m_idx == 0, m_idx == N - 1});
    check("in_ready", in_ready, e_ready);
    check("enable", enable, e_en);
    check("busy", busy, m_state != 0);
    check("sample_idx", sample_idx, m_idx);
    for (int s = 0; s < STAGES; s++) begin
      tw_s = 32'(tw_addr[s*LOG2N +: LOG2N]);
      check($sformatf("tw_addr_s%0d_n%0d", s, m_idx), tw_s, tw_ref(m_idx, s));
    end
    if (m_state == 1 && m_idx == 17) check("tw_n17_s0", tw_addr[5:0], 1);
    if (m_state == 1 && m_idx == 50) check("tw_n50_s0", tw_addr[5:0], 6);
    if (m_state == 1 && m_idx == 50) check("tw_n50_s1", tw_addr[11:6], 0);
    if (m_state == 1 && m_idx == 7)  check("tw_n7_s1", tw_addr[11:6], 12);
    check("tw_last_stage", tw_addr[17:12], 0);
    check("out_valid", out_valid, e_ov);
    check("out_sop", out_sop, e_sop);
    check("out_eop", out_eop, e_eop);
    check("err", err, m_err);
    if (enable === 1'b1) obs_en_cnt++;
    if (busy === 1'b1 && in_ready === 1'b0) flush_cyc++;
    if (out_valid === 1'b1) begin
      if (out_sop === 1'b1) begin sops++; sop_at = outs; end
      if (out_eop === 1'b1) begin eops++; eop_at = outs; end
      outs++;
    end
`ifdef FFT_FRAME_CTRL_ERR_EN
    if ((iv && m_state != 1) || (st && m_pend) || (st && m_state == 1 && m_idx == 0)) m_err = 1;
`endif
    case (m_state)
      0: if (st) begin m_state = 1; m_idx = 0; m_pend = 0; end
      1: begin
        if (iv && m_idx == N - 1) begin
          m_idx = 0;
          if (m_pend || st) m_pend = 0;
          else begin m_state = 2; m_fl = F; end
        end else begin
          if (iv) m_idx++;
          if (st) m_pend = 1;
        end
      end
      default: begin
        if (st) m_pend = 1;
        m_fl--;
        if (m_fl == 0) begin
          if (m_pend) begin m_state = 1; m_idx = 0; m_pend = 0; end
          else m_state = 0;
        end
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_enable", enable, 0);
    check("rst_sample_idx", sample_idx, 0);
    check("rst_tw_addr", tw_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sop", out_sop, 0);
    check("rst_out_eop", out_eop, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    m_state = 0; m_idx = 0; m_fl = 0; m_pend = 0; m_err = 0;
    en_cnt = 0; obs_en_cnt = 0;
    exq.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    clear_counts();
    do_reset();
    repeat (2) step(0, 0);

    // Single frame, gap-free.
    clear_counts();
    step(1, 0);
    for (int k = 0; k < N; k++) step(0, 1);
    repeat (12) step(0, 0);
    check("f1_outs", outs, N);
    check("f1_sops", sops, 1);
    check("f1_eops", eops, 1);
    check("f1_sop_pos", sop_at, 0);
    check("f1_eop_pos", eop_at, N - 1);
    check("f1_flush_len", flush_cyc, F);
    check("f1_busy_after", busy, 0);

    // Back-to-back with start mid-frame.
    clear_counts();
    step(1, 0);
    for (int k = 0; k < 2 * N; k++) step(k == 40, 1);
    repeat (12) step(0, 0);
    check("b2b_outs", outs, 2 * N);
    check("b2b_sops", sops, 2);
    check("b2b_eops", eops, 2);
    check("b2b_single_flush", flush_cyc, F);

    // Start coinciding with the last sample.
    clear_counts();
    step(1, 0);
    for (int k = 0; k < 2 * N; k++) step(k == N - 1, 1);
    repeat (12) step(0, 0);
    check("b2b_last_outs", outs, 2 * N);
    check("b2b_last_flush", flush_cyc, F);

    // Random input gaps, two chained frames.
    clear_counts();
    step(1, 0);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < N; k++) begin
        repeat ($urandom_range(0, 3)) step(0, 0);
        step(f == 0 && k == 20, 1);
      end
    end
    repeat (12) step(0, 0);
    check("gap_outs", outs, 2 * N);
    check("gap_sops", sops, 2);
    check("gap_eops", eops, 2);

    // Reset mid-frame at sample 30, then a clean frame.
    step(1, 0);
    for (int k = 0; k < 30; k++) step(0, 1);
    do_reset();
    clear_counts();
    step(1, 0);
    for (int k = 0; k < N; k++) step(0, 1);
    repeat (12) step(0, 0);
    check("post_rst_outs", outs, N);
    check("post_rst_sop_pos", sop_at, 0);
    check("post_rst_eop_pos", eop_at, N - 1);

    // in_valid while idle: flags only when the error logic is built in.
    step(0, 1);
    repeat (3) step(0, 0);
    do_reset();

    check("queue_drained", exq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_b4_frame_ctrl.md
# fft_b4_frame_ctrl

- Frame sequencer for the radix-4 single-path pipeline FFT built from the `pipe_line_b4_top_*` stages.
- Accepts an input sample stream framed by a start pulse and drives the shared `enable` that advances every stage.
- Generates each stage's twiddle ROM address from the in-frame sample index, flushes the pipeline tail after the last frame, and marks valid/SOP/EOP at the pipeline output.
- Sits between the sample source and stage 0, with a tag delay line that mirrors the datapath latency.

## Interface
- `STAGES`, 3: number of radix-4 stages; N = 4^STAGES.
- `LOG2N`, 6: must equal 2*STAGES.
- `LATENCY`, 8: datapath latency from stage-0 input to last-stage output, counted in enabled cycles; 1..64.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  frame request pulse.
- `in_valid`  in  1  input sample present.
- `in_ready`  out  1  controller accepts a sample this cycle.
- `enable`  out  1  pipeline advance to all stages.
- `sample_idx`  out  LOG2N  index of the current input sample within its frame.
- `tw_addr`  out  STAGES*LOG2N  twiddle ROM addresses; stage s uses bits [s*LOG2N +: LOG2N].
- `out_valid`  out  1  last-stage output is a real sample this cycle.
- `out_sop`  out  1  output sample is index 0 of a frame.
- `out_eop`  out  1  output sample is index N-1 of a frame.
- `busy`  out  1  state != IDLE.
- `err`  out  1  sticky protocol error (see Configuration).

## Operation
- Has three states: IDLE, RUN and FLUSH.
- IDLE:
  - `in_ready`=0 and `enable`=0.
  - `start`=1 → RUN with `sample_idx`=0.
- RUN:
  - `in_ready`=1 and `enable`=`in_valid`.
  - Each accepted sample increments `sample_idx`.
  - On an accepted sample with `sample_idx`=N-1, `sample_idx` wraps to 0. If `pend` is set, clear `pend` and stay in RUN (back-to-back frame, no bubble); otherwise go to FLUSH.
- `pend` is set by `start`=1 in RUN or FLUSH. A second `start` while `pend` is already set is ignored (error, see Configuration).
- FLUSH:
  - `in_ready`=0 and `enable`=1 for F cycles, F = LATENCY rounded up to a multiple of 4. This keeps the stage-internal mod-4 counters phase-aligned to frame boundaries.
  - The flush counter is reset on FLUSH entry.
  - At the end of the flush: if `pend` is set → RUN (clear `pend`), else → IDLE.
- The 2-bit `phase` counter increments on every `enable`. It equals 0 whenever `sample_idx`=0 is accepted, by construction.
- Twiddle address, computed combinationally from `sample_idx`=n for stage s:
  - L = N>>(2s), j = n mod L, p = j mod (L/4), q = j div (L/4).
  - `tw_addr`[s] = (p*q*4^s) mod N.
  - The last stage is always 0.
- Tag delay line: a LATENCY-deep shift register of {valid, sop, eop}, shifted only when `enable`=1.
  - Inserted tag = {RUN&`in_valid`, idx==0, idx==N-1}; zeros are inserted during FLUSH.
- Output flags:
  - `out_valid` = `enable` & tail.valid.
  - `out_sop` and `out_eop` are gated by `out_valid`.

## Timing
- Reset values:
  - Outputs: `in_ready`=0, `enable`=0, `sample_idx`=0, `tw_addr`=0, `out_*`=0, `busy`=0, `err`=0.
  - Internal state: state=IDLE, `pend`=0, `phase`=0, tag line all zero.
- Reset mid-frame discards all state immediately. The stages are reset by the same `rst`.
- `start` sampled at edge t puts the controller in RUN after that edge; `in_ready`=1 from cycle t+1.
- `tw_addr` is valid in the same cycle as its sample. The twiddle ROMs must be asynchronous-read.
- First `out_valid` of a frame occurs on the LATENCY-th enabled cycle after its sample 0 is accepted.
- Input gaps (`in_valid`=0 in RUN) stall the whole pipeline; they add no bubbles to the output.
- `start` and the last accepted sample in the same cycle count as a back-to-back request.

## Configuration
- Macro: `FFT_FRAME_CTRL_ERR_EN`.
- Defined: `err` is set, and held until reset, by any of:
  - `in_valid`=1 in IDLE or FLUSH;
  - `start` while `pend` is already set;
  - `start` in RUN with `sample_idx`=0 and no sample yet accepted.
- Undefined: no error logic is synthesised; `err` is tied 0.

## Test plan
- Reset then `start`, 64 continuous samples (N=64, LATENCY=8) → 64 `out_valid` cycles with `out_sop` on the first and `out_eop` on the 64th; the first `out_valid` falls 8 cycles after sample 0; FLUSH lasts 8 cycles; `busy` drops afterwards.
- Twiddle check:
  - n=17 → stage0 addr 1.
  - n=50 → stage0 addr 6, stage1 addr 0.
  - n=7 → stage1 addr 12.
  - Stage2 addr is always 0.
- Back-to-back: `start` during frame 1 → no FLUSH, frame 2 sample 0 accepted the cycle after sample 63, and output SOP/EOP stay contiguous.
- Random `in_valid` gaps of 0-3 cycles → same output sequence and count as the gap-free run; `phase`=0 at every sample 0.
- Assert `rst` at sample 30 → all outputs 0 in the same cycle; a new `start` produces a clean frame.
- With `FFT_FRAME_CTRL_ERR_EN`: `in_valid` in IDLE → `err`=1, held until reset. Without the macro: `err` stays 0.
